// File: rtl/game_timer_ctrl.sv
// Chess-clock sequencer: turn FSM, 1 Hz prescaler, BCD MM:SS round/total timers and game result.
// All outputs registered (one cycle after the causing edge); optional warn output built only with TIMER_WARN_EN.
module game_timer_ctrl #(
  parameter int          TICK_DIV   = 25000000,
  parameter logic [15:0] ROUND_INIT = 16'h0100,
  parameter logic [15:0] TOTAL_INIT = 16'h1000
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_done,
  input  logic        pause,
  input  logic [1:0]  ext_result,
  input  logic        ext_result_valid,
  output logic [15:0] rr_timer,
  output logic [15:0] rt_timer,
  output logic [15:0] br_timer,
  output logic [15:0] bt_timer,
  output logic        turn,
  output logic [1:0]  result,
  output logic        running,
  output logic        warn
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RED_RUN, BLACK_RUN, OVER} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [15:0]    rr_q, rr_d, rt_q, rt_d, br_q, br_d, bt_q, bt_d;
  logic           turn_q, turn_d;
  logic [1:0]     result_q, result_d;
  logic           running_q, running_d;
  logic [15:0]    round_dec, total_dec;

  // Borrow chain ss-units -> ss-tens -> mm-units -> mm-tens; saturates at 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v != 16'h0000) begin
      if (v[3:0] != 4'd0) begin
        r[3:0] = v[3:0] - 4'd1;
      end else begin
        r[3:0] = 4'd9;
        if (v[7:4] != 4'd0) begin
          r[7:4] = v[7:4] - 4'd1;
        end else begin
          r[7:4] = 4'd5;
          if (v[11:8] != 4'd0) begin
            r[11:8] = v[11:8] - 4'd1;
          end else begin
            r[11:8]  = 4'd9;
            r[15:12] = v[15:12] - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  assign round_dec = bcd_dec((state_q == BLACK_RUN) ? br_q : rr_q);
  assign total_dec = bcd_dec((state_q == BLACK_RUN) ? bt_q : rt_q);

`ifdef TIMER_WARN_EN
  logic warn_q, warn_d;
  logic move_taken;
`endif

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    rr_d     = rr_q;
    rt_d     = rt_q;
    br_d     = br_q;
    bt_d     = bt_q;
    turn_d   = turn_q;
    result_d = result_q;
`ifdef TIMER_WARN_EN
    move_taken = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RED_RUN;
          presc_d = '0;
          turn_d  = 1'b0;
        end
      end
      RED_RUN, BLACK_RUN: begin
        if (ext_result_valid && ext_result != 2'b00) begin
          result_d = ext_result;
          state_d  = OVER;
        end else if (move_done) begin
          // Incoming player's round restarts; a coinciding tick is dropped.
          state_d = (state_q == RED_RUN) ? BLACK_RUN : RED_RUN;
          turn_d  = ~turn_q;
          presc_d = '0;
          if (state_q == RED_RUN) br_d = ROUND_INIT;
          else                    rr_d = ROUND_INIT;
`ifdef TIMER_WARN_EN
          move_taken = 1'b1;
`endif
        end else if (!pause) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (state_q == RED_RUN) begin
              rr_d = round_dec;
              rt_d = total_dec;
            end else begin
              br_d = round_dec;
              bt_d = total_dec;
            end
            if (round_dec == 16'h0000 || total_dec == 16'h0000) begin
              state_d  = OVER;
              result_d = (state_q == RED_RUN) ? 2'b10 : 2'b01;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      OVER: begin
        if (start) begin
          state_d  = RED_RUN;
          presc_d  = '0;
          rr_d     = ROUND_INIT;
          br_d     = ROUND_INIT;
          rt_d     = TOTAL_INIT;
          bt_d     = TOTAL_INIT;
          turn_d   = 1'b0;
          result_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RED_RUN) || (state_d == BLACK_RUN);
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      rr_q      <= ROUND_INIT;
      br_q      <= ROUND_INIT;
      rt_q      <= TOTAL_INIT;
      bt_q      <= TOTAL_INIT;
      turn_q    <= 1'b0;
      result_q  <= 2'b00;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      rr_q      <= rr_d;
      br_q      <= br_d;
      rt_q      <= rt_d;
      bt_q      <= bt_d;
      turn_q    <= turn_d;
      result_q  <= result_d;
      running_q <= running_d;
    end
  end

`ifdef TIMER_WARN_EN
  // Evaluated on the next-cycle values of whichever player will be active.
  always_comb begin
    warn_d = 1'b0;
    if (running_d && !move_taken) begin
      if (state_d == RED_RUN) warn_d = (rr_d <= 16'h0010) || (rt_d <= 16'h0030);
      else                    warn_d = (br_d <= 16'h0010) || (bt_d <= 16'h0030);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) warn_q <= 1'b0;
    else     warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign rr_timer = rr_q;
  assign rt_timer = rt_q;
  assign br_timer = br_q;
  assign bt_timer = bt_q;
  assign turn     = turn_q;
  assign result   = result_q;
  assign running  = running_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Two DUT instances (small and minute-scale init values) share random stimulus; a seconds-based model predicts outputs.
module tb_game_timer_ctrl;

  typedef struct {
    logic [15:0] rr, rt, br, bt;
    logic        turn;
    logic [1:0]  result;
    logic        running;
    logic        warn;
  } obs_t;

  localparam int          TD0 = 4;
  localparam logic [15:0] RI0 = 16'h0003;
  localparam logic [15:0] TI0 = 16'h0010;
  localparam int          TD1 = 2;
  localparam logic [15:0] RI1 = 16'h0100;
  localparam logic [15:0] TI1 = 16'h1000;

  logic vga_clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, move_done = 1'b0, pause = 1'b0;
  logic [1:0] ext_result = 2'b00;
  logic ext_result_valid = 1'b0;

  logic [15:0] rr_o[2], rt_o[2], br_o[2], bt_o[2];
  logic        turn_o[2], running_o[2], warn_o[2];
  logic [1:0]  result_o[2];

  always #5 vga_clk = ~vga_clk;

  game_timer_ctrl #(.TICK_DIV(TD0), .ROUND_INIT(RI0), .TOTAL_INIT(TI0)) u_dut0 (
    .vga_clk(vga_clk), .rst(rst), .start(start), .move_done(move_done), .pause(pause),
    .ext_result(ext_result), .ext_result_valid(ext_result_valid),
    .rr_timer(rr_o[0]), .rt_timer(rt_o[0]), .br_timer(br_o[0]), .bt_timer(bt_o[0]),
    .turn(turn_o[0]), .result(result_o[0]), .running(running_o[0]), .warn(warn_o[0]));

  game_timer_ctrl #(.TICK_DIV(TD1), .ROUND_INIT(RI1), .TOTAL_INIT(TI1)) u_dut1 (
    .vga_clk(vga_clk), .rst(rst), .start(start), .move_done(move_done), .pause(pause),
    .ext_result(ext_result), .ext_result_valid(ext_result_valid),
    .rr_timer(rr_o[1]), .rt_timer(rt_o[1]), .br_timer(br_o[1]), .bt_timer(bt_o[1]),
    .turn(turn_o[1]), .result(result_o[1]), .running(running_o[1]), .warn(warn_o[1]));

  // Reference model: timers held as whole seconds, game as idle/playing/finished.
  int td[2], rinit[2], tinit[2];
  int rnd[2][2], tot[2][2];
  int phase[2], mode[2], act[2], res[2];
  bit wrn[2];
  obs_t q0[$], q1[$];
  int total = 0, bad = 0;

  function automatic int to_sec(input logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    logic [3:0] d3, d2, d1, d0;
    mm = s / 60;
    ss = s % 60;
    d3 = 4'(mm / 10);
    d2 = 4'(mm % 10);
    d1 = 4'(ss / 10);
    d0 = 4'(ss % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic model_reset(input int m);
    rnd[m][0] = rinit[m]; rnd[m][1] = rinit[m];
    tot[m][0] = tinit[m]; tot[m][1] = tinit[m];
    phase[m] = 0; mode[m] = 0; act[m] = 0; res[m] = 0; wrn[m] = 1'b0;
  endtask

  task automatic model_step(input int m, input bit r, input bit st, input bit mv,
                            input bit pz, input int er, input bit ev);
    bit moved;
    moved = 1'b0;
    if (r) begin
      model_reset(m);
    end else if (mode[m] == 0) begin
      if (st) begin mode[m] = 1; phase[m] = 0; act[m] = 0; end
    end else if (mode[m] == 2) begin
      if (st) begin
        model_reset(m);
        mode[m] = 1;
      end
    end else begin
      if (ev && er != 0) begin
        res[m] = er; mode[m] = 2;
      end else if (mv) begin
        act[m] = 1 - act[m];
        rnd[m][act[m]] = rinit[m];
        phase[m] = 0;
        moved = 1'b1;
      end else if (!pz) begin
        if (phase[m] == td[m] - 1) begin
          phase[m] = 0;
          if (rnd[m][act[m]] > 0) rnd[m][act[m]] = rnd[m][act[m]] - 1;
          if (tot[m][act[m]] > 0) tot[m][act[m]] = tot[m][act[m]] - 1;
          if (rnd[m][act[m]] == 0 || tot[m][act[m]] == 0) begin
            mode[m] = 2;
            res[m] = (act[m] == 0) ? 2 : 1;
          end
        end else begin
          phase[m] = phase[m] + 1;
        end
      end
    end
`ifdef TIMER_WARN_EN
    wrn[m] = (mode[m] == 1) && !moved && (rnd[m][act[m]] <= 10 || tot[m][act[m]] <= 30);
`else
    wrn[m] = 1'b0;
`endif
  endtask

  function automatic obs_t model_obs(input int m);
    obs_t o;
    o.rr = to_bcd(rnd[m][0]); o.rt = to_bcd(tot[m][0]);
    o.br = to_bcd(rnd[m][1]); o.bt = to_bcd(tot[m][1]);
    o.turn = act[m][0];
    o.result = res[m][1:0];
    o.running = (mode[m] == 1);
    o.warn = wrn[m];
    return o;
  endfunction

  task automatic drive(input bit r, input bit st, input bit mv, input bit pz,
                       input int er, input bit ev);
    @(negedge vga_clk);
    rst = r; start = st; move_done = mv; pause = pz;
    ext_result = er[1:0]; ext_result_valid = ev;
    model_step(0, r, st, mv, pz, er, ev);
    model_step(1, r, st, mv, pz, er, ev);
    q0.push_back(model_obs(0));
    q1.push_back(model_obs(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic check(input int m, input obs_t e);
    obs_t a;
    a.rr = rr_o[m]; a.rt = rt_o[m]; a.br = br_o[m]; a.bt = bt_o[m];
    a.turn = turn_o[m]; a.result = result_o[m]; a.running = running_o[m]; a.warn = warn_o[m];
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL dut%0d outputs @%0t: got rr=%h rt=%h br=%h bt=%h turn=%b res=%b run=%b warn=%b, want rr=%h rt=%h br=%h bt=%h turn=%b res=%b run=%b warn=%b",
               m, $time, a.rr, a.rt, a.br, a.bt, a.turn, a.result, a.running, a.warn,
               e.rr, e.rt, e.br, e.bt, e.turn, e.result, e.running, e.warn);
    end
  endtask

  // Monitor: every registered output set is compared against the oldest prediction.
  initial begin
    obs_t e;
    forever begin
      @(posedge vga_clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); check(0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); check(1, e); end
    end
  end

  initial begin
    int pause_left;
    td[0] = TD0; rinit[0] = to_sec(RI0); tinit[0] = to_sec(TI0);
    td[1] = TD1; rinit[1] = to_sec(RI1); tinit[1] = to_sec(TI1);
    model_reset(0);
    model_reset(1);

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(2);                                       // inputs ignored in IDLE
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);        // start
    idle(6);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);        // move to black
    idle(2);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    idle(5);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);        // start ignored, result 00 ignored
    idle(3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1);        // draw beats move_done
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);        // restart from OVER
    idle(20);                                      // red round timeout
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 7; i++) idle(3);
    for (int i = 0; i < 3; i++) begin              // move on a tick edge
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      idle(3);
    end

    pause_left = 0;
    for (int c = 0; c < 6000; c++) begin
      bit r, st, mv, pz, ev;
      int er;
      r  = ($urandom_range(0, 999) < 2);
      st = ($urandom_range(0, 29) == 0);
      mv = ($urandom_range(0, 9) == 0);
      ev = ($urandom_range(0, 79) == 0);
      er = $urandom_range(0, 3);
      if (pause_left > 0) begin
        pz = 1'b1;
        pause_left--;
      end else begin
        pz = 1'b0;
        if ($urandom_range(0, 59) == 0) pause_left = $urandom_range(1, 25);
      end
      drive(r, st, mv, pz, er, ev);
    end

    @(posedge vga_clk);
    #2;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d/%0d predictions left, want 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
